// File: rtl/iob_cache_be_write_pkg.sv
// Shared definitions for the IOb cache back-end write channel:
// write-policy selectors and the channel FSM state type.
package iob_cache_be_write_pkg;

    localparam int WRITE_THROUGH = 0;
    localparam int WRITE_BACK    = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WT_LOAD = 2'd1,
        WT_REQ  = 2'd2,
        WB_REQ  = 2'd3
    } be_write_state_t;

endpackage

// File: rtl/iob_cache_be_wlane.sv
// Places one front-end word onto the wider back-end bus: aligns the byte
// address, replicates the data across all lanes and shifts the strobes.
module iob_cache_be_wlane #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int BE_ADDR_W = 24,
    parameter int BE_DATA_W = 32
) (
    input  logic [ADDR_W-$clog2(DATA_W/8)-1:0] word_addr,
    input  logic [DATA_W-1:0]                  wdata,
    input  logic [DATA_W/8-1:0]                wstrb,
    output logic [BE_ADDR_W-1:0]               be_addr,
    output logic [BE_DATA_W-1:0]               be_wdata,
    output logic [BE_DATA_W/8-1:0]             be_wstrb
);

    localparam int BYTE_OFF_W = $clog2(DATA_W/8);
    localparam int BE_OFF_W   = $clog2(BE_DATA_W/8);
    localparam int R          = BE_DATA_W / DATA_W;
    localparam int R_W        = $clog2(R);
    localparam int STRB_W     = DATA_W / 8;
    localparam int BE_STRB_W  = BE_DATA_W / 8;

    localparam logic [BE_ADDR_W-1:0] ALIGN_MASK =
        ~((BE_ADDR_W'(1) << BE_OFF_W) - BE_ADDR_W'(1));

    assign be_addr  = (BE_ADDR_W'(word_addr) << BYTE_OFF_W) & ALIGN_MASK;
    assign be_wdata = {R{wdata}};

    // The lane index only exists when the back end is wider than a word.
    generate
        if (R == 1) begin : g_single_lane
            assign be_wstrb = wstrb;
        end else begin : g_multi_lane
            logic [R_W-1:0] lane;
            assign lane     = word_addr[R_W-1:0];
            assign be_wstrb = BE_STRB_W'(wstrb) << (32'(lane) * STRB_W);
        end
    endgenerate

endmodule

// File: rtl/iob_cache_be_write.sv
// Back-end write channel of the IOb cache: drains the write-through buffer
// or streams evicted dirty lines as IOb native write transactions.
module iob_cache_be_write
    import iob_cache_be_write_pkg::*;
#(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 32,
    parameter int BE_ADDR_W     = 24,
    parameter int BE_DATA_W     = 32,
    parameter int WORD_OFFSET_W = 3,
    parameter int WRITE_POL     = WRITE_THROUGH
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_n_i,
    input  logic                                                     wtb_empty_i,
    output logic                                                     wtb_read_o,
    input  logic [ADDR_W-$clog2(DATA_W/8)+DATA_W+DATA_W/8-1:0]      wtb_data_i,
    input  logic                                                     wb_valid_i,
    input  logic [ADDR_W-$clog2(DATA_W/8)-WORD_OFFSET_W-1:0]        wb_addr_i,
    input  logic [DATA_W*(2**WORD_OFFSET_W)-1:0]                     wb_data_i,
    output logic                                                     wb_ready_o,
    output logic                                                     be_iob_avalid_o,
    output logic [BE_ADDR_W-1:0]                                     be_iob_addr_o,
    output logic [BE_DATA_W-1:0]                                     be_iob_wdata_o,
    output logic [BE_DATA_W/8-1:0]                                   be_iob_wstrb_o,
    input  logic                                                     be_iob_ready_i,
    output logic                                                     busy_o
);

    localparam int FE_ADDR_W  = ADDR_W - $clog2(DATA_W/8);
    localparam int STRB_W     = DATA_W / 8;
    localparam int LINE_W     = DATA_W * (2**WORD_OFFSET_W);
    localparam int R          = BE_DATA_W / DATA_W;
    localparam int BEATS      = (2**WORD_OFFSET_W) / R;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF_W = WORD_OFFSET_W + $clog2(DATA_W/8);
    localparam int BE_BYTES   = BE_DATA_W / 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic IS_WT = (WRITE_POL == WRITE_THROUGH);
    localparam logic IS_WB = (WRITE_POL == WRITE_BACK);

    be_write_state_t state, state_nx;

    logic [BEAT_W-1:0]      beat;
    logic [BEAT_W-1:0]      beat_nx;
    logic [LINE_W-1:0]      line_q;
    logic                   load_wt;
    logic                   accept_wb;
    logic                   beat_adv;
    logic                   wt_done;
    logic                   wb_done;

    logic [FE_ADDR_W-1:0]   wtb_word_addr;
    logic [DATA_W-1:0]      wtb_wdata;
    logic [STRB_W-1:0]      wtb_wstrb;
    logic [BE_ADDR_W-1:0]   lane_addr;
    logic [BE_DATA_W-1:0]   lane_wdata;
    logic [BE_DATA_W/8-1:0] lane_wstrb;

    assign wtb_word_addr = wtb_data_i[FE_ADDR_W+DATA_W+STRB_W-1 -: FE_ADDR_W];
    assign wtb_wdata     = wtb_data_i[STRB_W +: DATA_W];
    assign wtb_wstrb     = wtb_data_i[STRB_W-1:0];
    assign beat_nx       = beat + 1'b1;

    iob_cache_be_wlane #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BE_ADDR_W (BE_ADDR_W),
        .BE_DATA_W (BE_DATA_W)
    ) u_wlane (
        .word_addr (wtb_word_addr),
        .wdata     (wtb_wdata),
        .wstrb     (wtb_wstrb),
        .be_addr   (lane_addr),
        .be_wdata  (lane_wdata),
        .be_wstrb  (lane_wstrb)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The FIFO pop is combinational so a completed write can chain straight
    // into the next entry; it is held off during reset so no entry is lost.
    always_comb begin
        state_nx   = state;
        wtb_read_o = 1'b0;
        load_wt    = 1'b0;
        accept_wb  = 1'b0;
        beat_adv   = 1'b0;
        wt_done    = 1'b0;
        wb_done    = 1'b0;
        case (state)
            IDLE: begin
                if (IS_WT) begin
                    if (!wtb_empty_i) begin
                        wtb_read_o = 1'b1;
                        state_nx   = WT_LOAD;
                    end
                end else if (wb_valid_i && !wb_ready_o) begin
                    accept_wb = 1'b1;
                    state_nx  = WB_REQ;
                end
            end
            WT_LOAD: begin
                load_wt  = 1'b1;
                state_nx = WT_REQ;
            end
            WT_REQ: begin
                if (be_iob_ready_i) begin
                    wt_done = 1'b1;
                    if (!wtb_empty_i) begin
                        wtb_read_o = 1'b1;
                        state_nx   = WT_LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            WB_REQ: begin
                if (be_iob_ready_i) begin
                    if (beat == LAST_BEAT) begin
                        wb_done  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        beat_adv = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!rst_n_i) begin
            wtb_read_o = 1'b0;
        end
    end

    // Back-end outputs are registered and only change on load, accept,
    // beat advance or completion, which keeps them stable across stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            be_iob_avalid_o <= 1'b0;
            be_iob_addr_o   <= '0;
            be_iob_wdata_o  <= '0;
            be_iob_wstrb_o  <= '0;
            wb_ready_o      <= 1'b0;
            beat            <= '0;
            line_q          <= '0;
        end else begin
            wb_ready_o <= wb_done;
            if (load_wt) begin
                be_iob_avalid_o <= 1'b1;
                be_iob_addr_o   <= lane_addr;
                be_iob_wdata_o  <= lane_wdata;
                be_iob_wstrb_o  <= lane_wstrb;
            end else if (accept_wb) begin
                be_iob_avalid_o <= 1'b1;
                be_iob_addr_o   <= BE_ADDR_W'(wb_addr_i) << LINE_OFF_W;
                be_iob_wdata_o  <= wb_data_i[BE_DATA_W-1:0];
                be_iob_wstrb_o  <= '1;
                beat            <= '0;
                line_q          <= wb_data_i;
            end else if (beat_adv) begin
                be_iob_addr_o  <= be_iob_addr_o + BE_ADDR_W'(BE_BYTES);
                be_iob_wdata_o <= line_q[beat_nx*BE_DATA_W +: BE_DATA_W];
                beat           <= beat_nx;
            end else if (wt_done || wb_done) begin
                be_iob_avalid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE)
                  | (IS_WT & !wtb_empty_i)
                  | (IS_WB & wb_valid_i & !wb_ready_o);

endmodule

// File: tb/tb_iob_cache_be_write.sv
// Self-checking bench: two write-through builds (64- and 32-bit back end)
// and one write-back build, checked against a transaction-level model.
module tb_iob_cache_be_write;

    typedef struct packed {
        logic [23:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rand_mode = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    // DUT a: write-through, 64-bit back end
    logic        a_empty = 1'b1;
    logic        a_read;
    logic [57:0] a_wtb_data = '0;
    logic        a_wbready, a_avalid, a_ready = 1'b0, a_busy;
    logic [23:0] a_addr;
    logic [63:0] a_wdata;
    logic [7:0]  a_wstrb;

    // DUT b: write-back, 64-bit back end
    logic         b_read;
    logic         b_valid = 1'b0;
    logic [19:0]  b_line  = '0;
    logic [127:0] b_data  = '0;
    logic         b_wbready, b_avalid, b_ready = 1'b0, b_busy;
    logic [23:0]  b_addr;
    logic [63:0]  b_wdata;
    logic [7:0]   b_wstrb;

    // DUT c: write-through, 32-bit back end
    logic        c_empty = 1'b1;
    logic        c_read;
    logic [57:0] c_wtb_data = '0;
    logic        c_wbready, c_avalid, c_ready = 1'b0, c_busy;
    logic [23:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;

    logic [57:0] a_fifo_q[$];
    logic [57:0] c_fifo_q[$];
    txn_t        a_exp_q[$];
    txn_t        b_exp_q[$];
    txn_t        c_exp_q[$];

    int a_pushes = 0, c_pushes = 0, b_lines = 0;
    int a_reads = 0, b_reads = 0, c_reads = 0;
    int a_pulses = 0, b_pulses = 0, c_pulses = 0;
    int b_hi = 0;

    iob_cache_be_write #(
        .ADDR_W(24), .DATA_W(32), .BE_ADDR_W(24), .BE_DATA_W(64),
        .WORD_OFFSET_W(2), .WRITE_POL(0)
    ) u_wt64 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wtb_empty_i(a_empty), .wtb_read_o(a_read), .wtb_data_i(a_wtb_data),
        .wb_valid_i(1'b0), .wb_addr_i(20'h0), .wb_data_i(128'h0), .wb_ready_o(a_wbready),
        .be_iob_avalid_o(a_avalid), .be_iob_addr_o(a_addr), .be_iob_wdata_o(a_wdata),
        .be_iob_wstrb_o(a_wstrb), .be_iob_ready_i(a_ready), .busy_o(a_busy)
    );

    iob_cache_be_write #(
        .ADDR_W(24), .DATA_W(32), .BE_ADDR_W(24), .BE_DATA_W(64),
        .WORD_OFFSET_W(2), .WRITE_POL(1)
    ) u_wb64 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wtb_empty_i(1'b1), .wtb_read_o(b_read), .wtb_data_i(58'h0),
        .wb_valid_i(b_valid), .wb_addr_i(b_line), .wb_data_i(b_data), .wb_ready_o(b_wbready),
        .be_iob_avalid_o(b_avalid), .be_iob_addr_o(b_addr), .be_iob_wdata_o(b_wdata),
        .be_iob_wstrb_o(b_wstrb), .be_iob_ready_i(b_ready), .busy_o(b_busy)
    );

    iob_cache_be_write #(
        .ADDR_W(24), .DATA_W(32), .BE_ADDR_W(24), .BE_DATA_W(32),
        .WORD_OFFSET_W(2), .WRITE_POL(0)
    ) u_wt32 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wtb_empty_i(c_empty), .wtb_read_o(c_read), .wtb_data_i(c_wtb_data),
        .wb_valid_i(1'b0), .wb_addr_i(20'h0), .wb_data_i(128'h0), .wb_ready_o(c_wbready),
        .be_iob_avalid_o(c_avalid), .be_iob_addr_o(c_addr), .be_iob_wdata_o(c_wdata),
        .be_iob_wstrb_o(c_wstrb), .be_iob_ready_i(c_ready), .busy_o(c_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected back-end write for one write-through entry, from byte arithmetic.
    function automatic txn_t wtExpect(input logic [21:0] wa, input logic [31:0] wd,
                                      input logic [3:0] ws, input int r);
        txn_t t;
        int unsigned ba;
        ba      = int'(wa) * 4;
        t.addr  = 24'(ba - ba % (r * 4));
        t.wdata = (r == 2) ? {wd, wd} : {32'h0, wd};
        t.wstrb = 8'(ws) << ((int'(wa) % r) * 4);
        return t;
    endfunction

    task automatic applyStimulus(input int which, input logic [21:0] wa,
                                 input logic [31:0] wd, input logic [3:0] ws);
        if (which == 0) begin
            a_fifo_q.push_back({wa, wd, ws});
            a_exp_q.push_back(wtExpect(wa, wd, ws, 2));
            a_pushes++;
        end else begin
            c_fifo_q.push_back({wa, wd, ws});
            c_exp_q.push_back(wtExpect(wa, wd, ws, 1));
            c_pushes++;
        end
    endtask

    task automatic requestWb(input logic [19:0] line, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        txn_t t;
        int   cnt;
        logic [31:0] words[4];
        words = '{w0, w1, w2, w3};
        for (int k = 0; k < 2; k++) begin
            t.addr  = 24'(int'(line) * 16 + k * 8);
            t.wdata = {words[2*k+1], words[2*k]};
            t.wstrb = 8'hFF;
            b_exp_q.push_back(t);
        end
        b_lines++;
        b_line  = line;
        b_data  = {w3, w2, w1, w0};
        b_valid = 1'b1;
        cnt = 0;
        while (cnt < 300) begin
            @(negedge clk);
            if (b_wbready) break;
            cnt++;
        end
        if (cnt >= 300) checkOutput("wb_ready_timeout", 64'(b_wbready), 64'd1);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int cnt = 0;
        while ((a_exp_q.size() + c_exp_q.size() + b_exp_q.size()) != 0 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= limit) begin
            checkOutput("drain_a_left", 64'(a_exp_q.size()), 64'd0);
            checkOutput("drain_b_left", 64'(b_exp_q.size()), 64'd0);
            checkOutput("drain_c_left", 64'(c_exp_q.size()), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    // Write-through FIFOs with one-cycle read latency and a registered empty flag.
    always @(posedge clk) begin
        if (a_read && a_fifo_q.size() > 0) a_wtb_data <= a_fifo_q.pop_front();
        a_empty <= (a_fifo_q.size() == 0);
        if (c_read && c_fifo_q.size() > 0) c_wtb_data <= c_fifo_q.pop_front();
        c_empty <= (c_fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            c_ready = 1'($urandom_range(0, 1));
        end
    end

    // Every presented request must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (a_read) a_reads++;
        if (b_read) b_reads++;
        if (c_read) c_reads++;
        if (a_wbready) a_pulses++;
        if (b_wbready) b_pulses++;
        if (c_wbready) c_pulses++;
        if (b_avalid) b_hi++;
        if (a_avalid) begin
            if (a_exp_q.size() == 0) checkOutput("a_spurious_avalid", 64'(a_avalid), 64'd0);
            else begin
                checkOutput("a_addr",  64'(a_addr),  64'(a_exp_q[0].addr));
                checkOutput("a_wdata", a_wdata,      a_exp_q[0].wdata);
                checkOutput("a_wstrb", 64'(a_wstrb), 64'(a_exp_q[0].wstrb));
                if (a_ready) void'(a_exp_q.pop_front());
            end
        end
        if (b_avalid) begin
            if (b_exp_q.size() == 0) checkOutput("b_spurious_avalid", 64'(b_avalid), 64'd0);
            else begin
                checkOutput("b_addr",  64'(b_addr),  64'(b_exp_q[0].addr));
                checkOutput("b_wdata", b_wdata,      b_exp_q[0].wdata);
                checkOutput("b_wstrb", 64'(b_wstrb), 64'(b_exp_q[0].wstrb));
                if (b_ready) void'(b_exp_q.pop_front());
            end
        end
        if (c_avalid) begin
            if (c_exp_q.size() == 0) checkOutput("c_spurious_avalid", 64'(c_avalid), 64'd0);
            else begin
                checkOutput("c_addr",  64'(c_addr),  64'(c_exp_q[0].addr));
                checkOutput("c_wdata", 64'(c_wdata), c_exp_q[0].wdata);
                checkOutput("c_wstrb", 64'(c_wstrb), 64'(c_exp_q[0].wstrb));
                if (c_ready) void'(c_exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat, first_hi, last_hi, hi_cnt, reads0, pulses0, hi0, cnt;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_a_avalid", 64'(a_avalid), 64'd0);
        checkOutput("rst_a_addr",   64'(a_addr),   64'd0);
        checkOutput("rst_a_wdata",  a_wdata,       64'd0);
        checkOutput("rst_a_wstrb",  64'(a_wstrb),  64'd0);
        checkOutput("rst_a_read",   64'(a_read),   64'd0);
        checkOutput("rst_a_busy",   64'(a_busy),   64'd0);
        checkOutput("rst_b_avalid", 64'(b_avalid), 64'd0);
        checkOutput("rst_b_wbready", 64'(b_wbready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single write-through entry, latency and lane placement
        a_ready = 1'b1;
        applyStimulus(0, 22'h000005, 32'hDEADBEEF, 4'hF);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!a_read && cnt < 20);
        checkOutput("t1_read_seen", 64'(a_read), 64'd1);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!a_avalid && lat < 20);
        checkOutput("t1_latency", 64'(lat), 64'd2);
        checkOutput("t1_addr",  64'(a_addr),  64'h10);
        checkOutput("t1_wdata", a_wdata,      64'hDEADBEEF_DEADBEEF);
        checkOutput("t1_wstrb", 64'(a_wstrb), 64'hF0);
        waitDrain(50);

        // 2: three queued entries with a zero-wait back end
        reads0 = a_reads;
        for (int i = 0; i < 3; i++) applyStimulus(0, 22'($urandom), $urandom, 4'($urandom));
        first_hi = -1; last_hi = -1; hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a_avalid) begin
                if (first_hi < 0) first_hi = i;
                last_hi = i;
                hi_cnt++;
            end
        end
        checkOutput("t2_avalid_cycles", 64'(hi_cnt), 64'd3);
        checkOutput("t2_avalid_span",   64'(last_hi - first_hi), 64'd4);
        checkOutput("t2_read_pulses",   64'(a_reads - reads0), 64'd3);
        waitDrain(50);

        // 3: back end stalls four cycles with a second entry queued
        a_ready = 1'b0;
        applyStimulus(0, 22'($urandom), $urandom, 4'($urandom));
        applyStimulus(0, 22'($urandom), $urandom, 4'($urandom));
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!a_avalid && cnt < 20);
        checkOutput("t3_avalid_seen", 64'(a_avalid), 64'd1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("t3_busy",   64'(a_busy), 64'd1);
            checkOutput("t3_no_pop", 64'(a_read), 64'd0);
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_pop_on_ready", 64'(a_read), 64'd1);
        waitDrain(50);

        // 4: one write-back line, zero-wait back end
        b_ready = 1'b1;
        pulses0 = b_pulses;
        hi0 = b_hi;
        requestWb(20'h01234, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        checkOutput("t4_wb_ready_pulses", 64'(b_pulses - pulses0), 64'd1);
        checkOutput("t4_beats_presented", 64'(b_hi - hi0), 64'd2);
        waitDrain(50);

        // 5: reset while the second beat is stalled
        b_line  = 20'h0ABCD;
        b_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 2; k++)
            b_exp_q.push_back('{addr: 24'(32'h0ABCD * 16 + k * 8),
                                wdata: b_data[k*64 +: 64], wstrb: 8'hFF});
        b_valid = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!b_avalid && cnt < 20);
        @(posedge clk); #1;
        b_ready = 1'b0;
        @(negedge clk);
        checkOutput("t5_beat1_addr", 64'(b_addr), 64'h0ABCD8);
        @(posedge clk); #1;
        rst_n   = 1'b0;
        b_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5_avalid", 64'(b_avalid), 64'd0);
        checkOutput("t5_addr",   64'(b_addr),   64'd0);
        checkOutput("t5_wdata",  b_wdata,       64'd0);
        checkOutput("t5_wstrb",  64'(b_wstrb),  64'd0);
        checkOutput("t5_wbready", 64'(b_wbready), 64'd0);
        checkOutput("t5_busy",   64'(b_busy),   64'd0);
        b_exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b1;
        requestWb(20'($urandom), $urandom, $urandom, $urandom, $urandom);
        waitDrain(50);

        // 6: 32-bit back end keeps the word in place
        c_ready = 1'b1;
        applyStimulus(1, 22'h000003, 32'hCAFE0123, 4'h3);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!c_avalid && cnt < 20);
        checkOutput("t6_addr",  64'(c_addr),  64'h00000C);
        checkOutput("t6_wdata", 64'(c_wdata), 64'hCAFE0123);
        checkOutput("t6_wstrb", 64'(c_wstrb), 64'h3);
        waitDrain(50);

        // Randomized traffic with random back-end stalls on all three builds
        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(0, 22'($urandom), $urandom, 4'($urandom));
            applyStimulus(1, 22'($urandom), $urandom, 4'($urandom));
        end
        for (int i = 0; i < 12; i++)
            requestWb(20'($urandom), $urandom, $urandom, $urandom, $urandom);
        waitDrain(3000);
        rand_mode = 1'b0;
        @(posedge clk); #1;

        checkOutput("end_a_reads",   64'(a_reads),  64'(a_pushes));
        checkOutput("end_c_reads",   64'(c_reads),  64'(c_pushes));
        checkOutput("end_b_pulses",  64'(b_pulses), 64'(b_lines));
        checkOutput("end_b_no_read", 64'(b_reads),  64'd0);
        checkOutput("end_wt_no_wbready", 64'(a_pulses + c_pulses), 64'd0);
        checkOutput("end_a_idle", 64'(a_busy), 64'd0);
        checkOutput("end_b_idle", 64'(b_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
